// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the multi-channel clock/strobe generator.
// Optional build macro: CLK_GEN_PHASE_EN adds a per-channel start phase.
package clk_gen_pkg;

  localparam int CNT_W = 16;
  localparam int CFG_W = 32;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
`ifdef CLK_GEN_PHASE_EN
    logic [CFG_W-1:0] phase;
`endif
  } ch_cfg_t;

  function automatic int clog2m1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_gen_ch.sv
// One divided-clock / tick channel with programmable period and high time.
// Optional build macro: CLK_GEN_PHASE_EN loads cnt from cfg.phase on write.
import clk_gen_pkg::*;

module clk_gen_ch #(
  parameter int CNT_W = clk_gen_pkg::CNT_W
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    wr,
  input  logic    adv,
  input  ch_cfg_t cfg,
  output logic    clk_out,
  output logic    tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] high;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wdiv;
  logic [CNT_W-1:0] whigh;
  logic [CNT_W-1:0] ld;
  logic [CNT_W-1:0] nxt;
  logic             wrap;
  logic             unused_hi;

  assign wdiv  = cfg.div[CNT_W-1:0];
  assign whigh = cfg.high[CNT_W-1:0];

`ifdef CLK_GEN_PHASE_EN
  logic [CNT_W-1:0] wphase;
  assign wphase = cfg.phase[CNT_W-1:0];
  assign ld = (wphase < wdiv) ? wphase : '0;
  assign unused_hi = |{cfg.div >> CNT_W,
                       cfg.high >> CNT_W,
                       cfg.phase >> CNT_W};
`else
  assign ld = '0;
  assign unused_hi = |{cfg.div >> CNT_W,
                       cfg.high >> CNT_W};
`endif

  assign wrap = (cnt == div - ONE);
  assign nxt  = wrap ? '0 : cnt + ONE;

  // Reload on write, step on advance, otherwise hold with tick cleared
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div     <= '0;
      high    <= '0;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (wr) begin
      div     <= wdiv;
      high    <= whigh;
      cnt     <= ld;
      clk_out <= (wdiv != '0) && (ld < whigh);
      tick    <= 1'b0;
    end else if (adv && div != '0) begin
      cnt     <= nxt;
      clk_out <= (nxt < high);
      tick    <= wrap;
    end else begin
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel clock/strobe generator with run-length counter and done.
// Optional build macro: CLK_GEN_PHASE_EN adds the cfg_phase input.
import clk_gen_pkg::*;

module clk_gen_multi #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = clk_gen_pkg::CNT_W,
  parameter int RUN_W      = 32,
  parameter int RUN_CYCLES = 100,
  localparam int CH_W      = clog2m1(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
`ifdef CLK_GEN_PHASE_EN
  input  logic [CNT_W-1:0]  cfg_phase,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [RUN_W-1:0]  run_count,
  output logic              done
);

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  ch_cfg_t cfg;
  logic    ch_ok;
  logic    adv;

  assign cfg.div  = CFG_W'(cfg_div);
  assign cfg.high = CFG_W'(cfg_high);
`ifdef CLK_GEN_PHASE_EN
  assign cfg.phase = CFG_W'(cfg_phase);
`endif

  assign ch_ok = (32'(cfg_ch) < 32'(NUM_CH));
  assign adv   = enable && !done && !clear;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_wr && ch_ok && (32'(cfg_ch) == 32'(i));
    clk_gen_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clock   (clock),
      .reset_n (reset_n),
      .wr      (wr),
      .adv     (adv),
      .cfg     (cfg),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

  // Count enabled cycles; done latches when the count reaches RUN_CYCLES
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_count <= '0;
      done      <= 1'b0;
    end else if (clear) begin
      run_count <= '0;
      done      <= 1'b0;
    end else if (enable && !done) begin
      run_count <= run_count + RUN_ONE;
      if (run_count == RUN_LAST)
        done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Self-checking bench for clk_gen_multi: vector table, directed corners,
// randomized traffic against a behavioural model.
module tb_clk_gen_multi;

  localparam int NCH = 5;
  localparam int CW  = 16;
  localparam int RW  = 32;
  localparam int RC  = 10;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           enable;
  logic           clear;
  logic           cfg_wr;
  logic [2:0]     cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic [CW-1:0]  cfg_high;
  logic [CW-1:0]  cfg_phase;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [RW-1:0]  run_count;
  logic           done;

  int checks = 0;
  int failures = 0;

  clk_gen_multi #(
    .NUM_CH     (NCH),
    .CNT_W      (CW),
    .RUN_W      (RW),
    .RUN_CYCLES (RC)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .clear     (clear),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
`ifdef CLK_GEN_PHASE_EN
    .cfg_phase (cfg_phase),
`endif
    .clk_out   (clk_out),
    .tick      (tick),
    .run_count (run_count),
    .done      (done)
  );

  always #5 clock = ~clock;

  // Behavioural model: position within the period, modulo arithmetic
  int mdiv[NCH];
  int mhigh[NCH];
  int mpos[NCH];
  bit mclk[NCH];
  bit mtick[NCH];
  int mrun;
  bit mdone;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mdiv[i] = 0; mhigh[i] = 0; mpos[i] = 0;
      mclk[i] = 0; mtick[i] = 0;
    end
    mrun = 0;
    mdone = 0;
  endtask

  task automatic model_step(input bit wr, input int ch, input int dv,
                            input int hi, input int ph, input bit en,
                            input bit clr);
    bit go;
    go = en && !mdone && !clr;
    for (int i = 0; i < NCH; i++) begin
      if (wr && ch == i) begin
        mdiv[i]  = dv;
        mhigh[i] = hi;
`ifdef CLK_GEN_PHASE_EN
        mpos[i]  = (ph < dv) ? ph : 0;
`else
        mpos[i]  = 0;
`endif
        mclk[i]  = (dv != 0) && (mpos[i] < hi);
        mtick[i] = 0;
      end else if (go && mdiv[i] != 0) begin
        mpos[i]  = (mpos[i] + 1) % mdiv[i];
        mtick[i] = (mpos[i] == 0);
        mclk[i]  = (mpos[i] < mhigh[i]);
      end else begin
        mtick[i] = 0;
      end
    end
    if (clr) begin
      mrun = 0;
      mdone = 0;
    end else if (en && !mdone) begin
      mrun++;
      if (mrun == RC) mdone = 1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic model_cmp(input string tag);
    logic [NCH-1:0] ec;
    logic [NCH-1:0] et;
    for (int i = 0; i < NCH; i++) begin
      ec[i] = mclk[i];
      et[i] = mtick[i];
    end
    chk({tag, ".clk_out"}, 64'(clk_out), 64'(ec));
    chk({tag, ".tick"}, 64'(tick), 64'(et));
    chk({tag, ".run_count"}, 64'(run_count), 64'(mrun));
    chk({tag, ".done"}, 64'(done), 64'(mdone));
  endtask

  task automatic cyc(input bit wr, input int ch, input int dv,
                     input int hi, input int ph, input bit en,
                     input bit clr, input string tag);
    cfg_wr    = wr;
    cfg_ch    = 3'(ch);
    cfg_div   = CW'(dv);
    cfg_high  = CW'(hi);
    cfg_phase = CW'(ph);
    enable    = en;
    clear     = clr;
    @(posedge clock);
    model_step(wr, ch, dv, hi, ph, en, clr);
    #1;
    model_cmp(tag);
  endtask

  typedef struct {
    bit wr; int ch; int dv; int hi; bit en; bit clr;
    logic [NCH-1:0] eclk; logic [NCH-1:0] etick; int erun; bit edone;
  } vec_t;

  function automatic vec_t mk(bit wr, int ch, int dv, int hi, bit en,
                              bit clr, logic [NCH-1:0] eclk,
                              logic [NCH-1:0] etick, int erun, bit edone);
    vec_t v;
    v.wr = wr; v.ch = ch; v.dv = dv; v.hi = hi; v.en = en; v.clr = clr;
    v.eclk = eclk; v.etick = etick; v.erun = erun; v.edone = edone;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    bit en_seq[8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    bit ck_seq[8] = '{1, 1, 1, 1, 1, 0, 0, 1};
    bit tk_seq[8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    // ch0 div=4 high=2: levels, tick, write-over-wrap, done, clear, bad ch
    tbl[0]  = mk(1, 0, 4, 2, 1, 0, 5'b00001, 5'b00000, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0, 1, 0, 5'b00001, 5'b00000, 2, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 0, 5'b00000, 5'b00000, 3, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 0, 5'b00000, 5'b00000, 4, 0);
    tbl[4]  = mk(0, 0, 0, 0, 1, 0, 5'b00001, 5'b00001, 5, 0);
    tbl[5]  = mk(0, 0, 0, 0, 1, 0, 5'b00001, 5'b00000, 6, 0);
    tbl[6]  = mk(0, 0, 0, 0, 1, 0, 5'b00000, 5'b00000, 7, 0);
    tbl[7]  = mk(0, 0, 0, 0, 1, 0, 5'b00000, 5'b00000, 8, 0);
    tbl[8]  = mk(1, 0, 4, 2, 1, 0, 5'b00001, 5'b00000, 9, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 0, 5'b00001, 5'b00000, 10, 1);
    tbl[10] = mk(0, 0, 0, 0, 1, 0, 5'b00001, 5'b00000, 10, 1);
    tbl[11] = mk(0, 0, 0, 0, 1, 1, 5'b00001, 5'b00000, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 0, 5'b00000, 5'b00000, 1, 0);
    tbl[13] = mk(1, 5, 1, 1, 0, 0, 5'b00000, 5'b00000, 1, 0);

    reset_n = 1'b0;
    enable = 0; clear = 0; cfg_wr = 0; cfg_ch = 0;
    cfg_div = 0; cfg_high = 0; cfg_phase = 0;
    model_reset();
    #12;
    chk("reset.clk_out", 64'(clk_out), 64'd0);
    chk("reset.tick", 64'(tick), 64'd0);
    chk("reset.run_count", 64'(run_count), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].wr, tbl[i].ch, tbl[i].dv, tbl[i].hi, 0,
          tbl[i].en, tbl[i].clr, "tbl");
      chk($sformatf("tbl%0d.clk_out", i), 64'(clk_out), 64'(tbl[i].eclk));
      chk($sformatf("tbl%0d.tick", i), 64'(tick), 64'(tbl[i].etick));
      chk($sformatf("tbl%0d.run", i), 64'(run_count), 64'(tbl[i].erun));
      chk($sformatf("tbl%0d.done", i), 64'(done), 64'(tbl[i].edone));
    end

    // Edge configurations on channels 1..4
    cyc(0, 0, 0, 0, 0, 0, 1, "edge.clr");
    cyc(1, 1, 1, 1, 0, 0, 0, "edge.w1");
    cyc(1, 2, 5, 0, 0, 0, 0, "edge.w2");
    cyc(1, 3, 3, 7, 0, 0, 0, "edge.w3");
    cyc(1, 4, 0, 3, 0, 0, 0, "edge.w4");
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 0, "edge.run");
      chk("edge.div1_tick", 64'(tick[1]), 64'd1);
      chk("edge.high0_clk", 64'(clk_out[2]), 64'd0);
      chk("edge.highgediv_clk", 64'(clk_out[3]), 64'd1);
      chk("edge.div0_clk", 64'(clk_out[4]), 64'd0);
      chk("edge.div0_tick", 64'(tick[4]), 64'd0);
    end

    // Enable low for 3 cycles mid-period on div=5 high=3
    cyc(0, 0, 0, 0, 0, 0, 1, "hold.clr");
    cyc(1, 0, 5, 3, 0, 0, 0, "hold.wr");
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0, en_seq[i], 0, "hold.seq");
      chk($sformatf("hold%0d.clk", i), 64'(clk_out[0]), 64'(ck_seq[i]));
      chk($sformatf("hold%0d.tick", i), 64'(tick[0]), 64'(tk_seq[i]));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 7),
          $urandom_range(0, 6), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 4) != 0,
          $urandom_range(0, 11) == 0, "rand");
    end

    // Asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset.clk_out", 64'(clk_out), 64'd0);
    chk("areset.tick", 64'(tick), 64'd0);
    chk("areset.run_count", 64'(run_count), 64'd0);
    chk("areset.done", 64'(done), 64'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7),
          $urandom_range(0, 6), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 4) != 0,
          $urandom_range(0, 11) == 0, "rand2");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
